// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction at a time over a req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors instead of forcing alignment.
module lsu #(
  parameter int CPU_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_op,
  input  logic [CPU_WIDTH-1:0] req_addr,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  output logic                 rsp_valid,
  output logic [4:0]           rsp_rd,
  output logic [CPU_WIDTH-1:0] rsp_data,
  output logic                 rsp_err
);
  // state | meaning
  // IDLE  | ready for a new request
  // REQ   | mem_req held with stable bus outputs until mem_gnt
  // WAIT  | granted, waiting for mem_rvalid or timeout
  // ERR   | illegal request, error response next cycle
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t               state;
  logic [2:0]           op_q;
  logic [1:0]           off_q;
  logic [4:0]           rd_q;
  logic                 we_q;
  logic [7:0]           to_cnt;

  logic                 illegal;
  logic [1:0]           off;
  logic [3:0]           strb;
  logic [CPU_WIDTH-1:0] wdata_rep;
  logic [CPU_WIDTH-1:0] shifted;
  logic [CPU_WIDTH-1:0] load_data;

  assign req_ready = (state == IDLE);

  // Decode of the offered request; off already has any forced alignment applied.
  always_comb begin
    off       = req_addr[1:0];
    illegal   = req_we ? (req_op >= 3'b011)
                       : (req_op == 3'b011 || req_op[2:1] == 2'b11);
    strb      = 4'b1111;
    wdata_rep = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        strb      = 4'b0001 << off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_addr[0]) illegal = 1'b1;
`endif
        off[0]    = 1'b0;
        strb      = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
        off = 2'b00;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      to_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            off_q <= off;
            rd_q  <= req_rd;
            we_q  <= req_we;
            if (illegal) begin
              state <= ERR;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[CPU_WIDTH-1:2], 2'b00};
              mem_wstrb <= req_we ? strb : 4'b0000;
              mem_wdata <= req_we ? wdata_rep : '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            to_cnt  <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_rd    <= rd_q;
            rsp_err   <= 1'b0;
            rsp_data  <= we_q ? '0 : load_data;
          end else if (to_cnt == TO_LIMIT) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_rd    <= rd_q;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else if (to_cnt != 8'hFF) begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rd    <= rd_q;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: bench-driven memory bus, responses checked against a scoreboard queue.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  lsu #(.CPU_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Effective offset: halfwords drop bit 0, words drop both bits.
  function automatic int eff_off(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b01:   return (a[1] ? 2 : 0);
      2'b10:   return 0;
      default: return int'(a);
    endcase
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] op, input logic [31:0] addr);
    logic ok;
    if (we) ok = (op == 3'd0 || op == 3'd1 || op == 3'd2);
    else    ok = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if (op[1:0] == 2'b01 && addr[0]) ok = 1'b0;
    if (op[1:0] == 2'b10 && addr[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [7:0]  by [4];
    logic [15:0] h;
    int o;
    for (int i = 0; i < 4; i++) by[i] = rdata[8*i +: 8];
    o = eff_off(op, addr[1:0]);
    h = {by[(o + 1) % 4], by[o]};
    case (op)
      3'd0:    return {{24{by[o][7]}}, by[o]};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, by[o]};
      3'd5:    return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] s;
    int o;
    s = 4'b0000;
    o = eff_off(op, addr[1:0]);
    case (op)
      3'd0:    s[o] = 1'b1;
      3'd1:    begin s[o] = 1'b1; s[o+1] = 1'b1; end
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      case (op)
        3'd0:    r[8*i +: 8] = wd[7:0];
        3'd1:    r[8*i +: 8] = wd[8*(i%2) +: 8];
        default: r[8*i +: 8] = wd[8*i +: 8];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_t e;
      chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd,
                     input logic [31:0] rdata, input int gdly);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step;
    req_valid = 1'b0;
    if (!legal(we, op, addr)) begin
      chk("err_no_mem_req", 32'(mem_req), 32'd0);
      sb_q.push_back(rsp_t'{rd: rd, data: 32'd0, err: 1'b1});
      step;
      chk("err_no_mem_req2", 32'(mem_req), 32'd0);
      chk("err_rsp_cycle2", 32'(rsp_valid), 32'd1);
    end else begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, wa);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_wstrb", 32'(mem_wstrb), we ? 32'(exp_strb(op, addr)) : 32'd0);
      if (we) chk("mem_wdata", mem_wdata, exp_wdata(op, wdata));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      for (int i = 0; i < gdly; i++) begin
        step;
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", mem_addr, wa);
        chk("ready_hold", 32'(req_ready), 32'd0);
      end
      mem_gnt = 1'b1;
      step;
      mem_gnt = 1'b0;
      chk("req_drop", 32'(mem_req), 32'd0);
      chk("ready_wait", 32'(req_ready), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      sb_q.push_back(rsp_t'{rd: rd, data: (we ? 32'd0 : exp_load(op, addr, rdata)), err: 1'b0});
      step;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
      chk("ready_again", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step; step;
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd1, 32'h80AA_BBCC, 0);
    txn(1'b0, 3'd5, 32'h0000_0202, 32'h0, 5'd2, 32'h8001_1234, 0);
    txn(1'b0, 3'd1, 32'h0000_0202, 32'h0, 5'd3, 32'h8001_1234, 0);
    txn(1'b1, 3'd0, 32'h0000_0301, 32'h1234_56AB, 5'd4, 32'h0, 0);
    txn(1'b0, 3'd2, 32'h0000_0500, 32'h0, 5'd5, 32'hDEAD_BEEF, 4);
    txn(1'b1, 3'd1, 32'h0000_0302, 32'hCAFE_1234, 5'd6, 32'h0, 1);
    txn(1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344, 5'd7, 32'h0, 0);
    txn(1'b0, 3'd4, 32'h0000_0101, 32'h0, 5'd8, 32'h1234_8A56, 0);
    step;
    chk("rsp_pulse_one_cycle", 32'(rsp_valid), 32'd0);
    chk("rsp_data_hold", rsp_data, 32'h0000_008A);
    chk("rsp_rd_hold", 32'(rsp_rd), 32'd8);

    txn(1'b0, 3'd3, 32'h0000_0000, 32'h0, 5'd9, 32'h0, 0);
    txn(1'b1, 3'd4, 32'h0000_0040, 32'h55, 5'd10, 32'h0, 0);
    txn(1'b0, 3'd7, 32'h0000_0044, 32'h0, 5'd11, 32'h0, 0);
    txn(1'b0, 3'd2, 32'h0000_0402, 32'h0, 5'd12, 32'hA1B2_C3D4, 0);
    txn(1'b0, 3'd5, 32'h0000_0203, 32'h0, 5'd13, 32'h8001_1234, 0);

    // stray bus events while idle produce nothing
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step; step;
    mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = '0;
    chk("stray_no_req", 32'(mem_req), 32'd0);
    chk("stray_ready", 32'(req_ready), 32'd1);

    // timeout after 9 WAIT cycles with TIMEOUT_CYCLES=8
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd2; req_addr = 32'h600; req_rd = 5'd14;
    step;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    sb_q.push_back(rsp_t'{rd: 5'd14, data: 32'd0, err: 1'b1});
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      step;
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd9);
    txn(1'b0, 3'd2, 32'h0000_0700, 32'h0, 5'd15, 32'h0BAD_F00D, 0);

    // reset while waiting: no response, late rvalid ignored
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd2; req_addr = 32'h800; req_rd = 5'd16;
    step;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step;
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("late_rvalid_ignored", 32'(rsp_valid), 32'd0);
    step;
    chk("late_rvalid_ignored2", 32'(rsp_valid), 32'd0);
    txn(1'b0, 3'd0, 32'h0000_0900, 32'h0, 5'd17, 32'h0000_007F, 2);
    step;

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
